// File: rtl/wb_grf.sv
// Write-back stage and 32x32 general register file with same-cycle W->D bypass.
// Optional macro WB_TRACE_EN adds a simulation-only trace of every committed write.
module wb_grf #(
    parameter logic [31:0] SP_INIT = 32'h0000_0000,
    parameter logic [31:0] GP_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_W,
    input  logic [31:0] PC8_W,
    input  logic [31:0] AO_W,
    input  logic [31:0] DR_W,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic        we_out,
    output logic [4:0]  wa_out,
    output logic [31:0] wd_out
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        dec_we;
    logic [4:0]  dec_wa;
    logic [31:0] dec_wd;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    assign op    = IR_W[31:26];
    assign funct = IR_W[5:0];
    assign rt    = IR_W[20:16];
    assign rd    = IR_W[15:11];

    // Lane selection for sub-word loads; AO_W[0] is ignored for halfwords.
    always_comb begin
        ld_byte = DR_W[7:0];
        case (AO_W[1:0])
            2'd0: ld_byte = DR_W[7:0];
            2'd1: ld_byte = DR_W[15:8];
            2'd2: ld_byte = DR_W[23:16];
            2'd3: ld_byte = DR_W[31:24];
            default: ld_byte = DR_W[7:0];
        endcase
        ld_half = AO_W[1] ? DR_W[31:16] : DR_W[15:0];
    end

    always_comb begin
        dec_we = 1'b0;
        dec_wa = 5'd0;
        dec_wd = 32'd0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h00: begin
                        dec_we = 1'b1;
                        dec_wa = rd;
                        dec_wd = AO_W;
                    end
                    6'h09: begin
                        dec_we = 1'b1;
                        dec_wa = rd;
                        dec_wd = PC8_W;
                    end
                    default: ;
                endcase
            end
            6'h0d, 6'h0f, 6'h09: begin
                dec_we = 1'b1;
                dec_wa = rt;
                dec_wd = AO_W;
            end
            6'h23: begin
                dec_we = 1'b1;
                dec_wa = rt;
                dec_wd = DR_W;
            end
            6'h20: begin
                dec_we = 1'b1;
                dec_wa = rt;
                dec_wd = {{24{ld_byte[7]}}, ld_byte};
            end
            6'h24: begin
                dec_we = 1'b1;
                dec_wa = rt;
                dec_wd = {24'd0, ld_byte};
            end
            6'h21: begin
                dec_we = 1'b1;
                dec_wa = rt;
                dec_wd = {{16{ld_half[15]}}, ld_half};
            end
            6'h25: begin
                dec_we = 1'b1;
                dec_wa = rt;
                dec_wd = {16'd0, ld_half};
            end
            6'h03: begin
                dec_we = 1'b1;
                dec_wa = 5'd31;
                dec_wd = PC8_W;
            end
            default: ;
        endcase
    end

    assign we_out = dec_we && (dec_wa != 5'd0) && !reset;
    assign wa_out = dec_wa;
    assign wd_out = dec_wd;

    // Reset reloads the pointer registers; $0 is forced to zero every cycle.
    always_comb begin
        regs_d = regs_q;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_d[i] = 32'd0;
            end
            regs_d[28] = GP_INIT;
            regs_d[29] = SP_INIT;
        end else if (we_out) begin
            regs_d[wa_out] = wd_out;
        end
        regs_d[0] = 32'd0;
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    always_comb begin
        rd1 = regs_q[ra1];
        rd2 = regs_q[ra2];
        if (ra1 == 5'd0) begin
            rd1 = 32'd0;
        end else if (we_out && (wa_out == ra1)) begin
            rd1 = wd_out;
        end
        if (ra2 == 5'd0) begin
            rd2 = 32'd0;
        end else if (we_out && (wa_out == ra2)) begin
            rd2 = wd_out;
        end
    end

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (we_out) begin
            $display("@%08h: $%02d <= %08h", PC8_W - 32'd8, wa_out, wd_out);
        end
    end
`else
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Scoreboard bench for wb_grf: expectations are queued at drive time and
// compared against the DUT just before the next rising edge.
module tb_wb_grf;

    localparam logic [31:0] SP_VAL = 32'h0000_3FFC;
    localparam logic [31:0] GP_VAL = 32'h0000_1800;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_W, PC8_W, AO_W, DR_W;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        we_out;
    logic [4:0]  wa_out;
    logic [31:0] wd_out;

    typedef struct {
        string       tag;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_regs [32];
    int          num_vectors = 0;
    int          num_errors  = 0;

    wb_grf #(.SP_INIT(SP_VAL), .GP_INIT(GP_VAL)) dut (
        .clk(clk), .reset(reset), .IR_W(IR_W), .PC8_W(PC8_W), .AO_W(AO_W),
        .DR_W(DR_W), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we_out(we_out), .wa_out(wa_out), .wd_out(wd_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_vectors++;
        if (got !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_regs[28] = GP_VAL;
        model_regs[29] = SP_VAL;
    endtask

    // Drives one W-stage cycle; ewe is the expected gated enable, ewa/ewd the decoded target.
    task automatic applyStimulus(input string tag, input logic rst,
                                 input logic [31:0] ir, input logic [31:0] pc8,
                                 input logic [31:0] ao, input logic [31:0] dr,
                                 input logic [4:0] a1, input logic [4:0] a2,
                                 input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd);
        exp_t e;
        exp_t o;
        @(negedge clk);
        reset = rst; IR_W = ir; PC8_W = pc8; AO_W = ao; DR_W = dr; ra1 = a1; ra2 = a2;
        e.tag = tag; e.we = ewe; e.wa = ewa; e.wd = ewd;
        e.rd1 = (a1 == 5'd0) ? 32'd0 : (ewe && ewa == a1) ? ewd : model_regs[a1];
        e.rd2 = (a2 == 5'd0) ? 32'd0 : (ewe && ewa == a2) ? ewd : model_regs[a2];
        sb_q.push_back(e);
        #2;
        o = sb_q.pop_front();
        checkOutput({o.tag, ".we"},  {31'd0, we_out}, {31'd0, o.we});
        checkOutput({o.tag, ".wa"},  {27'd0, wa_out}, {27'd0, o.wa});
        checkOutput({o.tag, ".wd"},  wd_out, o.wd);
        checkOutput({o.tag, ".rd1"}, rd1, o.rd1);
        checkOutput({o.tag, ".rd2"}, rd2, o.rd2);
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else if (ewe) model_regs[ewa] = ewd;
    endtask

    initial begin
        reset = 1'b1; IR_W = '0; PC8_W = '0; AO_W = '0; DR_W = '0; ra1 = '0; ra2 = '0;
        repeat (2) @(posedge clk);
        model_reset();

        applyStimulus("rst_hold", 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 5'd28, 5'd29, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            applyStimulus($sformatf("rst_read%0d", i), 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                          5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0);
        end

        applyStimulus("ori_byp", 1'b0, 32'h3408_1234, 32'h0, 32'h0000_1234, 32'h0, 5'd8, 5'd0, 1'b1, 5'd8, 32'h0000_1234);
        applyStimulus("ori_arr", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd8, 1'b0, 5'd0, 32'h0);
        if (model_regs[8] != 32'h0000_1234) checkOutput("model8", model_regs[8], 32'h0000_1234);
        applyStimulus("addu_r0", 1'b0, 32'h0022_0021, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd8, 1'b0, 5'd0, 32'hFFFF_FFFF);
        applyStimulus("addu_r3", 1'b0, 32'h0022_1821, 32'h0, 32'hCAFE_F00D, 32'h0, 5'd3, 5'd8, 1'b1, 5'd3, 32'hCAFE_F00D);

        applyStimulus("lb3",  1'b0, 32'h800A_0003, 32'h0, 32'h0000_1003, 32'h80FF_7F01, 5'd10, 5'd3, 1'b1, 5'd10, 32'hFFFF_FF80);
        applyStimulus("lbu3", 1'b0, 32'h900B_0003, 32'h0, 32'h0000_1003, 32'h80FF_7F01, 5'd11, 5'd10, 1'b1, 5'd11, 32'h0000_0080);
        applyStimulus("lh0",  1'b0, 32'h840C_0000, 32'h0, 32'h0000_1000, 32'h80FF_7F01, 5'd12, 5'd11, 1'b1, 5'd12, 32'h0000_7F01);
        applyStimulus("lhu2", 1'b0, 32'h940D_0002, 32'h0, 32'h0000_1002, 32'h80FF_7F01, 5'd13, 5'd12, 1'b1, 5'd13, 32'h0000_80FF);
        applyStimulus("lb1",  1'b0, 32'h800E_0001, 32'h0, 32'h0000_1001, 32'h80FF_7F01, 5'd14, 5'd13, 1'b1, 5'd14, 32'h0000_007F);
        applyStimulus("lh3",  1'b0, 32'h840F_0003, 32'h0, 32'h0000_1003, 32'h80FF_7F01, 5'd15, 5'd14, 1'b1, 5'd15, 32'hFFFF_80FF);
        applyStimulus("lw",   1'b0, 32'h8C06_0000, 32'h0, 32'h0000_1000, 32'h1234_5678, 5'd15, 5'd6, 1'b1, 5'd6, 32'h1234_5678);

        applyStimulus("jal",  1'b0, 32'h0C00_0C00, 32'h0000_3008, 32'h0, 32'h0, 5'd6, 5'd31, 1'b1, 5'd31, 32'h0000_3008);
        applyStimulus("jalr", 1'b0, 32'h0140_4809, 32'h0000_300C, 32'h0, 32'h0, 5'd31, 5'd9, 1'b1, 5'd9, 32'h0000_300C);
        applyStimulus("sw",   1'b0, 32'hAD09_0000, 32'h0000_3010, 32'h0000_0040, 32'h5555_5555, 5'd9, 5'd31, 1'b0, 5'd0, 32'h0);
        for (int i = 8; i < 16; i++) begin
            applyStimulus($sformatf("sweep%0d", i), 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                          5'(i), 5'(i - 5), 1'b0, 5'd0, 32'h0);
        end

        applyStimulus("rst_lw", 1'b1, 32'h8C05_0000, 32'h0000_3014, 32'h0, 32'hDEAD_BEEF, 5'd5, 5'd31, 1'b0, 5'd5, 32'hDEAD_BEEF);
        applyStimulus("post5",  1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31, 1'b0, 5'd0, 32'h0);
        applyStimulus("post29", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd29, 5'd28, 1'b0, 5'd0, 32'h0);
        applyStimulus("post9",  1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd8, 1'b0, 5'd0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_errors);
        $finish;
    end

endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Write-back stage plus general register file for the 5-stage MIPS pipeline.
- Consumes the MEM/WB pipeline-register outputs (instruction, PC+8, ALU result, memory read data).
- Decodes the write target, extends load data, and writes the 32x32 GRF.
- Serves the two D-stage read ports, with internal W->D bypass, and exports write info for upstream forwarding/hazard logic.

Parameters:
- SP_INIT, 32'h0000_0000, reset value of $29.
- GP_INIT, 32'h0000_0000, reset value of $28.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset
- IR_W  in  32  W-stage instruction
- PC8_W  in  32  W-stage PC+8
- AO_W  in  32  W-stage ALU result / memory address
- DR_W  in  32  raw word read from data memory
- ra1  in  5  D-stage read address 1 (rs)
- ra2  in  5  D-stage read address 2 (rt)
- rd1  out  32  read data 1
- rd2  out  32  read data 2
- we_out  out  1  write enable this cycle (after $0 masking)
- wa_out  out  5  write address this cycle
- wd_out  out  32  write data this cycle

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All state updates occur on posedge clk.
- Decode rules (op = IR_W[31:26], funct = IR_W[5:0]):
  - op 0 with funct addu 0x21, subu 0x23, and 0x24, or 0x25, slt 0x2a, sll 0x00: wa = rd, data = AO_W.
  - op 0 with funct jalr 0x09: wa = rd, data = PC8_W.
  - ori 0x0d, lui 0x0f, addiu 0x09: wa = rt, data = AO_W.
  - lw 0x23: wa = rt, data = DR_W.
  - lb 0x20, lbu 0x24: wa = rt, data = byte DR_W[8*AO_W[1:0] +: 8], sign- or zero-extended respectively.
  - lh 0x21, lhu 0x25: wa = rt, data = halfword DR_W[16*AO_W[1] +: 16], sign- or zero-extended; AO_W[0] ignored.
  - jal 0x03: wa = 31, data = PC8_W.
  - All other opcodes (sw, beq, bne, j, jr, unknown): no write.
- Write gating:
  - we_out = decoded-write AND wa != 0 AND !reset.
  - wa_out and wd_out are always the decoded values, zero when no decoded write.
  - IR_W = 0 (nop/bubble) gives we_out = 0.
- Register array:
  - On posedge with reset = 1: all registers cleared, then $28 = GP_INIT, $29 = SP_INIT; no write performed.
  - Otherwise, if we_out, reg[wa_out] <= wd_out.
  - $0 is never written and always reads 0.
- Reads (combinational, zero latency):
  - rd1 = 0 if ra1 == 0.
  - else rd1 = wd_out if we_out && wa_out == ra1 (same-cycle bypass).
  - else rd1 = reg[ra1].
  - rd2 follows the same rule with ra2.
  - Net effect: a write and a read of the same register in one cycle return the new value.
- Reset:
  - While reset is high, bypass is inhibited (we_out = 0); reads return the array contents.
  - Reset asserted mid-stream discards the W-stage write of that cycle.
- Output values after reset: we_out = 0 when IR_W = 0; rd1/rd2 = 0 except addresses 28/29, which return GP_INIT/SP_INIT.

Optional Feature:
- Macro: WB_TRACE_EN.
- When defined: on each posedge with we_out = 1, issue a simulation display of the form "@<PC8_W-8, 8 hex digits>: $<wa_out, decimal 2 digits> <= <wd_out, 8 hex digits>". No display for suppressed writes ($0, reset, non-writing ops).
- When undefined: no display code is compiled; RTL behaviour is identical.

Test Plan:
- Reset, then read all addresses -> rd = 0 everywhere except $28 = GP_INIT, $29 = SP_INIT; we_out = 0 with IR_W = 0.
- IR_W = ori $8,$0,0x1234 (0x34081234), AO_W = 0x00001234, ra1 = 8 in the same cycle -> rd1 = 0x00001234 via bypass; next cycle with IR_W = 0 -> rd1 = 0x00001234 from the array.
- IR_W = addu $0,$1,$2 (0x00220021), AO_W = 0xFFFFFFFF -> we_out = 0; rd1 with ra1 = 0 stays 0.
- DR_W = 0x80FF7F01, varying AO_W[1:0]:
  - lb, AO_W = 0x...3 -> 0xFFFFFF80.
  - lbu, AO_W = 0x...3 -> 0x00000080.
  - lh, AO_W = 0x...0 -> 0x00007F01.
  - lhu, AO_W = 0x...2 -> 0x000080FF.
- jal (0x0C000C00), PC8_W = 0x00003008 -> reg[31] = 0x00003008; jalr $9,$10 (0x01404809), PC8_W = 0x0000300C -> reg[9] = 0x0000300C; sw (0xAD090000) -> no register changes.
- Reset asserted in the same cycle as lw $5 (0x8C050000), DR_W = 0xDEADBEEF -> reg[5] = 0 afterwards; with WB_TRACE_EN defined, no trace line is printed for that cycle.
